// File: rtl/pcs_rx_sync_pkg.sv
// Shared types, constants and word classifier for the 16-bit PCS receive sync monitor.
package pcs_rx_sync_pkg;

  typedef enum logic [1:0] {
    LOS    = 2'd0,
    ACQ    = 2'd1,
    SYNCED = 2'd2,
    CHECK  = 2'd3
  } t_sync_state;

  localparam logic [7:0] c_K28_5   = 8'hBC;
  localparam logic [1:0] c_COMMA_K = 2'b10;

  typedef struct packed {
    logic comma;
    logic invalid;
  } t_word_class;

  // A comma is only usable for alignment when it sits in the first byte on the wire.
  function automatic t_word_class f_classify_word(input logic [15:0] data,
                                                  input logic [1:0]  k,
                                                  input logic        enc_err);
    t_word_class c;
    c.comma   = (k == c_COMMA_K) && (data[15:8] == c_K28_5) && !enc_err;
    c.invalid = enc_err || ((k == 2'b01) && (data[7:0] == c_K28_5)) || (k == 2'b11);
    return c;
  endfunction

endpackage

// File: rtl/pcs_rx_sync_monitor_16b_if.sv
// Decoded receive word bundle from the 8b10b decoder into the sync monitor.
interface pcs_rx_sync_monitor_16b_if;
  logic [15:0] rx_data;
  logic [1:0]  rx_k;
  logic        rx_enc_err;
  logic        rx_valid;

  modport master (output rx_data, rx_k, rx_enc_err, rx_valid);
  modport slave  (input  rx_data, rx_k, rx_enc_err, rx_valid);
endinterface

// File: rtl/pcs_rx_sat_counter.sv
// Saturating up-counter with synchronous clear, used for receive statistics.
module pcs_rx_sat_counter #(
  parameter int g_width = 16
) (
  input  logic               clk_sys_i,
  input  logic               rst_n_i,
  input  logic               clear_i,
  input  logic               inc_i,
  output logic [g_width-1:0] cnt_o
);

  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i)
      cnt_o <= '0;
    else if (clear_i)
      cnt_o <= '0;
    else if (inc_i && (cnt_o != '1))
      cnt_o <= cnt_o + 1'b1;
  end

endmodule

// File: rtl/pcs_rx_sync_monitor_16b.sv
// Receive sync monitor: cl.36-style LOS/ACQ/SYNCED/CHECK FSM on decoded 16-bit words.
// Statistics counters are built only when PCS_RX_SYNC_STATS_EN is defined.
module pcs_rx_sync_monitor_16b
  import pcs_rx_sync_pkg::*;
#(
  parameter int g_commas_to_sync  = 3,
  parameter int g_errs_to_lose    = 4,
  parameter int g_good_to_recover = 4,
  parameter int g_cnt_width       = 16
) (
  input  logic                          clk_sys_i,
  input  logic                          rst_n_i,
  pcs_rx_sync_monitor_16b_if.slave      rx,
  input  logic                          force_los_i,
  output logic                          sync_o,
  output logic                          sync_gained_p1_o,
  output logic                          sync_lost_p1_o,
  output logic [g_cnt_width-1:0]        err_cnt_o,
  output logic [g_cnt_width-1:0]        comma_cnt_o,
  output logic [1:0]                    state_o
);

  localparam logic [3:0] c_commas_to_sync  = 4'(g_commas_to_sync);
  localparam logic [3:0] c_errs_to_lose    = 4'(g_errs_to_lose);
  localparam logic [3:0] c_good_to_recover = 4'(g_good_to_recover);

  t_word_class cls;
  logic        word_comma, word_invalid, word_good;
  t_sync_state state_q, state_d;
  logic [3:0]  acq_q, acq_d, bad_q, bad_d, good_q, good_d;

  assign cls          = f_classify_word(rx.rx_data, rx.rx_k, rx.rx_enc_err);
  assign word_comma   = rx.rx_valid && cls.comma;
  assign word_invalid = rx.rx_valid && cls.invalid;
  assign word_good    = rx.rx_valid && !cls.invalid;

  always_comb begin
    state_d = state_q;
    acq_d   = acq_q;
    bad_d   = bad_q;
    good_d  = good_q;
    if (force_los_i) begin
      state_d = LOS;
      acq_d   = '0;
      bad_d   = '0;
      good_d  = '0;
    end else begin
      case (state_q)
        LOS: if (word_comma) begin
          acq_d   = 4'd1;
          state_d = (c_commas_to_sync == 4'd1) ? SYNCED : ACQ;
        end
        ACQ: if (word_invalid) begin
          acq_d   = '0;
          state_d = LOS;
        end else if (word_comma) begin
          acq_d = acq_q + 4'd1;
          if (acq_q + 4'd1 == c_commas_to_sync) state_d = SYNCED;
        end
        SYNCED: if (word_invalid) begin
          bad_d   = 4'd1;
          good_d  = '0;
          state_d = (c_errs_to_lose == 4'd1) ? LOS : CHECK;
        end
        CHECK: if (word_invalid) begin
          bad_d  = bad_q + 4'd1;
          good_d = '0;
          if (bad_q + 4'd1 == c_errs_to_lose) begin
            bad_d   = '0;
            state_d = LOS;
          end
        end else if (word_good) begin
          // Each full run of good words retires one outstanding error.
          if (good_q + 4'd1 == c_good_to_recover) begin
            good_d = '0;
            bad_d  = bad_q - 4'd1;
            if (bad_q == 4'd1) state_d = SYNCED;
          end else begin
            good_d = good_q + 4'd1;
          end
        end
        default: state_d = LOS;
      endcase
    end
  end

  // Status outputs are derived from the next state so they land together with it.
  always_ff @(posedge clk_sys_i or posedge rst_n_i) begin
    if (rst_n_i) begin
      state_q          <= LOS;
      acq_q            <= '0;
      bad_q            <= '0;
      good_q           <= '0;
      sync_o           <= 1'b0;
      sync_gained_p1_o <= 1'b0;
      sync_lost_p1_o   <= 1'b0;
    end else begin
      state_q          <= state_d;
      acq_q            <= acq_d;
      bad_q            <= bad_d;
      good_q           <= good_d;
      sync_o           <= (state_d == SYNCED) || (state_d == CHECK);
      sync_gained_p1_o <= (state_d == SYNCED) && ((state_q == LOS) || (state_q == ACQ));
      sync_lost_p1_o   <= (state_d == LOS) && ((state_q == SYNCED) || (state_q == CHECK));
    end
  end

  assign state_o = state_q;

`ifdef PCS_RX_SYNC_STATS_EN
  pcs_rx_sat_counter #(.g_width(g_cnt_width)) u_err_cnt (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (1'b0),
    .inc_i     (word_invalid),
    .cnt_o     (err_cnt_o)
  );

  pcs_rx_sat_counter #(.g_width(g_cnt_width)) u_comma_cnt (
    .clk_sys_i (clk_sys_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (1'b0),
    .inc_i     (word_comma),
    .cnt_o     (comma_cnt_o)
  );
`else
  assign err_cnt_o   = '0;
  assign comma_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pcs_rx_sync_monitor_16b.sv
// Directed self-checking bench for pcs_rx_sync_monitor_16b (works with or without PCS_RX_SYNC_STATS_EN).
module tb_pcs_rx_sync_monitor_16b;

  logic        clk_sys_i = 1'b0;
  logic        rst_n_i   = 1'b1;
  logic        force_los_i = 1'b0;
  logic        sync_o, sync_gained_p1_o, sync_lost_p1_o;
  logic [15:0] err_cnt_o, comma_cnt_o;
  logic [1:0]  state_o;
  int          checks = 0;
  int          errors = 0;

`ifdef PCS_RX_SYNC_STATS_EN
  localparam bit c_stats_en = 1'b1;
`else
  localparam bit c_stats_en = 1'b0;
`endif

  pcs_rx_sync_monitor_16b_if rx_if ();

  pcs_rx_sync_monitor_16b dut (
    .clk_sys_i        (clk_sys_i),
    .rst_n_i          (rst_n_i),
    .rx               (rx_if),
    .force_los_i      (force_los_i),
    .sync_o           (sync_o),
    .sync_gained_p1_o (sync_gained_p1_o),
    .sync_lost_p1_o   (sync_lost_p1_o),
    .err_cnt_o        (err_cnt_o),
    .comma_cnt_o      (comma_cnt_o),
    .state_o          (state_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;

  function automatic logic [15:0] expCnt(input int v);
    return c_stats_en ? 16'(v) : 16'h0000;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input logic [1:0] st, input logic sync,
                            input logic gained, input logic lost);
    checkOutput({tag, ".state"},  32'(state_o),          32'(st));
    checkOutput({tag, ".sync"},   32'(sync_o),           32'(sync));
    checkOutput({tag, ".gained"}, 32'(sync_gained_p1_o), 32'(gained));
    checkOutput({tag, ".lost"},   32'(sync_lost_p1_o),   32'(lost));
  endtask

  task automatic checkCounters(input string tag, input int errs, input int commas);
    checkOutput({tag, ".err_cnt"},   32'(err_cnt_o),   32'(expCnt(errs)));
    checkOutput({tag, ".comma_cnt"}, 32'(comma_cnt_o), 32'(expCnt(commas)));
  endtask

  // One call drives one word for exactly one clock; outputs are sampled 1ns after that edge.
  task automatic applyStimulus(input logic [15:0] data, input logic [1:0] k, input logic enc_err,
                               input logic valid, input logic force_los);
    rx_if.rx_data    = data;
    rx_if.rx_k       = k;
    rx_if.rx_enc_err = enc_err;
    rx_if.rx_valid   = valid;
    force_los_i      = force_los;
    @(posedge clk_sys_i);
    #1;
  endtask

  task automatic sendComma();
    applyStimulus(16'hBC50, 2'b10, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic sendIdle();
    applyStimulus(16'h0000, 2'b00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Comma presented during reset must not advance anything.
    rx_if.rx_data    = 16'hBC50;
    rx_if.rx_k       = 2'b10;
    rx_if.rx_enc_err = 1'b0;
    rx_if.rx_valid   = 1'b1;
    #12;
    checkState("reset", 2'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset.err_cnt",   32'(err_cnt_o),   32'h0);
    checkOutput("reset.comma_cnt", 32'(comma_cnt_o), 32'h0);
    rx_if.rx_valid = 1'b0;
    rst_n_i        = 1'b0;

    // Scenario 1: three aligned commas acquire sync.
    sendComma();  checkState("s1.c1", 2'd1, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s1.c2", 2'd1, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s1.c3", 2'd2, 1'b1, 1'b1, 1'b0);
    checkCounters("s1", 0, 3);
    sendIdle();   checkState("s1.idle", 2'd2, 1'b1, 1'b0, 1'b0);

    // Scenario 2: four misaligned commas lose sync.
    applyStimulus(16'h00BC, 2'b01, 1'b0, 1'b1, 1'b0); checkState("s2.w1", 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h00BC, 2'b01, 1'b0, 1'b1, 1'b0); checkState("s2.w2", 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h00BC, 2'b01, 1'b0, 1'b1, 1'b0); checkState("s2.w3", 2'd3, 1'b1, 1'b0, 1'b0);
    applyStimulus(16'h00BC, 2'b01, 1'b0, 1'b1, 1'b0); checkState("s2.w4", 2'd0, 1'b0, 1'b0, 1'b1);
    checkCounters("s2", 4, 3);
    sendIdle();   checkState("s2.idle", 2'd0, 1'b0, 1'b0, 1'b0);

    sendComma(); sendComma(); sendComma();
    checkState("reacq", 2'd2, 1'b1, 1'b1, 1'b0);

    // Scenario 3: one error then four good words recover to SYNCED without pulses.
    applyStimulus(16'h1234, 2'b00, 1'b1, 1'b1, 1'b0); checkState("s3.err", 2'd3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(16'h1234, 2'b00, 1'b0, 1'b1, 1'b0);
      checkState($sformatf("s3.g%0d", i + 1), 2'd3, 1'b1, 1'b0, 1'b0);
    end
    applyStimulus(16'h1234, 2'b00, 1'b0, 1'b1, 1'b0); checkState("s3.g4", 2'd2, 1'b1, 1'b0, 1'b0);
    checkCounters("s3", 5, 6);

    // Scenario 5: forced loss during a comma word.
    applyStimulus(16'hBC50, 2'b10, 1'b0, 1'b1, 1'b1); checkState("s5.force", 2'd0, 1'b0, 1'b0, 1'b1);
    checkCounters("s5", 5, 7);
    sendIdle();   checkState("s5.idle", 2'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 4: invalid word in ACQ restarts acquisition.
    sendComma(); sendComma();
    checkState("s4.acq2", 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h0000, 2'b11, 1'b0, 1'b1, 1'b0); checkState("s4.inv", 2'd0, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s4.c1", 2'd1, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s4.c2", 2'd1, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s4.c3", 2'd2, 1'b1, 1'b1, 1'b0);
    checkCounters("s4", 6, 12);

    // Held force keeps LOS despite commas; lost pulses only once.
    applyStimulus(16'hBC50, 2'b10, 1'b0, 1'b1, 1'b1); checkState("hold.1", 2'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus(16'hBC50, 2'b10, 1'b0, 1'b1, 1'b1); checkState("hold.2", 2'd0, 1'b0, 1'b0, 1'b0);

    // Scenario 6: invalid data with rx_valid low is ignored between commas.
    sendComma();  checkState("s6.c1", 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h00BC, 2'b11, 1'b1, 1'b0, 1'b0); checkState("s6.x1", 2'd1, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s6.c2", 2'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(16'h00BC, 2'b11, 1'b1, 1'b0, 1'b0); checkState("s6.x2", 2'd1, 1'b0, 1'b0, 1'b0);
    sendComma();  checkState("s6.c3", 2'd2, 1'b1, 1'b1, 1'b0);
    checkCounters("s6", 6, 17);

    // Error counter saturates rather than wrapping.
    rx_if.rx_data    = 16'h0000;
    rx_if.rx_k       = 2'b11;
    rx_if.rx_enc_err = 1'b0;
    rx_if.rx_valid   = 1'b1;
    repeat (65541) @(posedge clk_sys_i);
    #1;
    checkOutput("sat.err_cnt", 32'(err_cnt_o), 32'(expCnt(65535)));
    checkOutput("sat.comma_cnt", 32'(comma_cnt_o), 32'(expCnt(17)));
    checkOutput("sat.state", 32'(state_o), 32'd0);
    sendIdle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
